sr_cmd_ctrl: RTL and testbench

//  Upstream command stage for sr_ff. Two asynchronous request lines (set/clear) are synchronised,

---
 rtl/sr_cmd_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sr_cmd_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_ctrl.sv
// Command front end for sr_ff: synchronises, debounces and edge-detects the set/clear request
// lines, then serialises them into one-cycle s/r pulses that are never asserted together.
module sr_cmd_ctrl #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_model
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_SET  = 4'b0010,
        ST_CLR  = 4'b0100,
        ST_HOLD = 4'b1000
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LIM   = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Index 0 is the set channel, index 1 the clear channel throughout.
    logic [1:0]            req_s;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            lvl_q;
    logic [1:0]            lvl_d;
    logic [1:0][CNT_W-1:0] deb_cnt_q;
    logic [1:0][CNT_W-1:0] deb_cnt_d;
    logic [1:0]            rise_s;
    logic [1:0]            pend_q;
    logic [1:0]            pend_d;
    logic [1:0]            consume_s;
    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      hold_cnt_q;
    logic [CNT_W-1:0]      hold_cnt_d;
    logic                  q_model_q;
    logic                  q_model_d;
    logic                  conflict_s;

    assign req_s = {clr_req, set_req};

    // Debounce: a level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        lvl_d     = lvl_q;
        deb_cnt_d = deb_cnt_q;
        rise_s    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if ((deb_cnt_q[i] + CNT_ONE) == DEB_LIM) begin
                    lvl_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                    rise_s[i]    = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    // Pending events: consumed by the FSM, re-armed by a debounced rise (rises merge, never queue).
    always_comb begin
        pend_d = (pend_q & ~consume_s) | rise_s;
    end

    // Synchroniser, debounce and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            lvl_q     <= 2'b00;
            deb_cnt_q <= '0;
            pend_q    <= 2'b00;
        end else begin
            sync1_q   <= req_s;
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            deb_cnt_q <= deb_cnt_d;
            pend_q    <= pend_d;
        end
    end

    // Arbitration FSM: next state, holdoff counter, event consumption and flop-state model.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        consume_s  = 2'b00;
        conflict_s = 1'b0;
        q_model_d  = q_model_q;
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (pend_q == 2'b11) begin
                    conflict_s = 1'b1;
                    consume_s  = 2'b11;
                    if (HOLD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (pend_q[0]) begin
                    consume_s = 2'b01;
                    state_d   = ST_SET;
                end else if (pend_q[1]) begin
                    consume_s = 2'b10;
                    state_d   = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SET, ST_CLR: begin
                hold_cnt_d = '0;
                q_model_d  = (state_q == ST_SET) ? 1'b1 : 1'b0;
                if (HOLD_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            default: begin
                hold_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // FSM state, holdoff counter and q_model registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            q_model_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            q_model_q  <= q_model_d;
        end
    end

    // Outputs decode flops only, so s and r cannot glitch and are mutually exclusive by encoding.
    assign s        = (state_q == ST_SET);
    assign r        = (state_q == ST_CLR);
    assign busy     = (state_q != ST_IDLE);
    assign conflict = conflict_s;
    assign q_model  = q_model_q;

endmodule

// File: tb/tb_sr_cmd_ctrl.sv
// Randomised and directed bench for sr_cmd_ctrl against a timeline-based reference model.
module tb_sr_cmd_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 2;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic set_req;
    logic clr_req;
    logic s;
    logic r;
    logic busy;
    logic conflict;
    logic q_model;

    sr_cmd_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .s(s), .r(r), .busy(busy), .conflict(conflict), .q_model(q_model)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: raw-sample history, mismatch run lengths and a service timeline.
    bit     m_hist0[$];
    bit     m_hist1[$];
    bit [1:0] m_lvl;
    bit [1:0] m_pend;
    int     m_run[2];
    int     m_idle_from;
    int     m_pulse_at[2];
    bit     m_q;

    int last_cmd;
    int cnt_s, cnt_r, cnt_busy, cnt_conf, first_s, first_r;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_hist0.delete();
        m_hist1.delete();
        m_lvl       = 2'b00;
        m_pend      = 2'b00;
        m_run[0]    = 0;
        m_run[1]    = 0;
        m_idle_from = 0;
        m_pulse_at[0] = -100;
        m_pulse_at[1] = -100;
        m_q         = 1'b0;
    endfunction

    // Advance the model across the edge numbered cyc, given the inputs that edge sampled.
    task automatic model_step(input bit in_s, input bit in_c);
        bit d[2];
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (cyc - 1 >= m_idle_from) begin
            if (m_pend == 2'b11) begin
                m_pend      = 2'b00;
                m_idle_from = cyc + HOLD;
            end else if (m_pend[0]) begin
                m_pend[0]     = 1'b0;
                m_pulse_at[0] = cyc;
                m_idle_from   = cyc + 1 + HOLD;
            end else if (m_pend[1]) begin
                m_pend[1]     = 1'b0;
                m_pulse_at[1] = cyc;
                m_idle_from   = cyc + 1 + HOLD;
            end
        end
        if (m_pulse_at[0] == cyc - 1) m_q = 1'b1;
        else if (m_pulse_at[1] == cyc - 1) m_q = 1'b0;
        d[0] = (m_hist0.size() >= 2) ? m_hist0[1] : 1'b0;
        d[1] = (m_hist1.size() >= 2) ? m_hist1[1] : 1'b0;
        m_hist0.push_front(in_s);
        m_hist1.push_front(in_c);
        if (m_hist0.size() > 3) void'(m_hist0.pop_back());
        if (m_hist1.size() > 3) void'(m_hist1.pop_back());
        for (int k = 0; k < 2; k++) begin
            if (d[k] != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_lvl[k] = d[k];
                    m_run[k] = 0;
                    if (d[k]) m_pend[k] = 1'b1;
                end
            end else begin
                m_run[k] = 0;
            end
        end
    endtask

    task automatic clear_counts();
        cnt_s = 0; cnt_r = 0; cnt_busy = 0; cnt_conf = 0; first_s = -1; first_r = -1;
    endtask

    // One clock: drive at the falling edge, check #1 after the rising edge, return at the falling edge.
    task automatic cycle(input logic sv, input logic cv);
        set_req = sv;
        clr_req = cv;
        @(posedge clk);
        #1;
        cyc++;
        model_step(sv, cv);
        if (!rst_n) last_cmd = -1;
        chk_eq("s", s, (m_pulse_at[0] == cyc) ? 1 : 0);
        chk_eq("r", r, (m_pulse_at[1] == cyc) ? 1 : 0);
        chk_eq("busy", busy, (cyc < m_idle_from) ? 1 : 0);
        chk_eq("conflict", conflict, ((cyc >= m_idle_from) && (m_pend == 2'b11)) ? 1 : 0);
        chk_eq("q_model", q_model, m_q);
        chk_eq("s_and_r", s & r, 0);
        if (s === 1'b1 || r === 1'b1) begin
            if (last_cmd >= 0) chk_eq("cmd_spacing", ((cyc - last_cmd) >= 2 + HOLD) ? 1 : 0, 1);
            last_cmd = cyc;
        end
        if (s === 1'b1) begin cnt_s++; if (first_s < 0) first_s = cyc; end
        if (r === 1'b1) begin cnt_r++; if (first_r < 0) first_r = cyc; end
        if (busy === 1'b1) cnt_busy++;
        if (conflict === 1'b1) cnt_conf++;
        @(negedge clk);
    endtask

    initial begin
        int  e0;
        bit  found;
        int  hs, hc;
        logic vs, vc;
        rst_n = 1'b0; set_req = 1'b0; clr_req = 1'b0;
        model_reset();
        last_cmd = -1;
        clear_counts();
        @(negedge clk);
        repeat (3) cycle(1'b0, 1'b0);
        chk_eq("rst_s", s, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_q", q_model, 0);
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 1'b0);

        // Single set request held high.
        clear_counts();
        e0 = cyc + 1;
        repeat (20) cycle(1'b1, 1'b0);
        chk_eq("t1_latency_edge", first_s - e0 + 1, 3 + DEB);
        chk_eq("t1_s_count", cnt_s, 1);
        chk_eq("t1_r_count", cnt_r, 0);
        chk_eq("t1_busy_cycles", cnt_busy, 1 + HOLD);
        chk_eq("t1_q_after", q_model, 1);
        repeat (10) cycle(1'b0, 1'b0);

        // Glitch shorter than the debounce window.
        clear_counts();
        repeat (DEB - 1) cycle(1'b1, 1'b0);
        repeat (15) cycle(1'b0, 1'b0);
        chk_eq("t2_s_count", cnt_s, 0);
        chk_eq("t2_busy_cycles", cnt_busy, 0);

        // Simultaneous set and clear.
        clear_counts();
        repeat (12) cycle(1'b1, 1'b1);
        chk_eq("t3_conflict_cycles", cnt_conf, 1);
        chk_eq("t3_s_count", cnt_s, 0);
        chk_eq("t3_r_count", cnt_r, 0);
        chk_eq("t3_busy_cycles", cnt_busy, HOLD);
        chk_eq("t3_q_held", q_model, 1);
        repeat (12) cycle(1'b0, 1'b0);

        // Clear arriving while the set command is in holdoff.
        clear_counts();
        repeat (2) cycle(1'b1, 1'b0);
        repeat (18) cycle(1'b1, 1'b1);
        chk_eq("t4_s_count", cnt_s, 1);
        chk_eq("t4_r_count", cnt_r, 1);
        chk_eq("t4_r_gap", first_r - first_s, 2 + HOLD);
        chk_eq("t4_conflict_cycles", cnt_conf, 0);
        chk_eq("t4_q_final", q_model, 0);
        repeat (10) cycle(1'b0, 1'b0);

        // Asynchronous reset in the middle of a SET cycle.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b1, 1'b0);
            if (m_pulse_at[0] == cyc) found = 1'b1;
        end
        chk_eq("t5_reached_set", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("t5_async_s", s, 0);
        chk_eq("t5_async_busy", busy, 0);
        chk_eq("t5_async_q", q_model, 0);
        model_reset();
        last_cmd = -1;
        repeat (2) cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 1'b0);
        chk_eq("t5_post_busy", busy, 0);
        chk_eq("t5_post_q", q_model, 0);

        // Back-to-back set pulses.
        clear_counts();
        for (int p = 0; p < 3; p++) begin
            repeat (5) cycle(1'b1, 1'b0);
            repeat (5) cycle(1'b0, 1'b0);
        end
        repeat (10) cycle(1'b0, 1'b0);
        chk_eq("t6_s_count", cnt_s, 3);
        chk_eq("t6_q_final", q_model, 1);

        // Random request traffic.
        hs = 0; hc = 0; vs = 1'b0; vc = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 20) == 0) begin
                vs = 1'b1; vc = 1'b1; hs = 7; hc = 7;
            end
            if (hs == 0) begin vs = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 12); end
            if (hc == 0) begin vc = 1'($urandom_range(0, 1)); hc = $urandom_range(1, 12); end
            hs--; hc--;
            cycle(vs, vc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
